// File: rtl/fetch_prefetch_queue.sv
// Instruction fetch front end: issues sequential word fetches, buffers in-order
// responses and feeds the Decode register, with stall and redirect handling.
module fetch_prefetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] outstanding_reg;
    logic [CW-1:0] drop_cnt_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rpc_rd_reg;
    logic [PW-1:0] rpc_wr_reg;

    logic [31:0] q_pc    [DEPTH];
    logic [31:0] q_instr [DEPTH];
    logic [31:0] rpc     [DEPTH];

    logic [CW:0]   credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_next;
    logic [1:0]    unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];

    // Credit counts both buffered and in-flight slots, so every response has room.
    assign credit           = {1'b0, count_reg} + {1'b0, outstanding_reg};
    assign imem_req_valid   = !rst && !redirect_valid && (credit < DEPTH_W);
    assign imem_req_addr    = fetch_pc_reg;
    assign accept           = imem_req_valid && imem_req_ready;
    assign push             = imem_rsp_valid && !redirect_valid && (drop_cnt_reg == '0);
    assign pop              = !redirect_valid && !stall_d && (count_reg != '0);
    assign outstanding_next = outstanding_reg + CW'(accept) - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_reg]    <= rpc[rpc_rd_reg];
            q_instr[wr_ptr_reg] <= imem_rsp_data;
        end
        if (accept) begin
            rpc[rpc_wr_reg] <= fetch_pc_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= RESET_PC;
            count_reg       <= '0;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            rpc_rd_reg      <= '0;
            rpc_wr_reg      <= '0;
            InstrD          <= NOP_INSTR;
            PCD             <= 32'h0;
            PCPlus4D        <= 32'h0;
            ValidD          <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            if (accept) begin
                fetch_pc_reg <= fetch_pc_reg + 32'd4;
                rpc_wr_reg   <= rpc_wr_reg + PW'(1);
            end
            // Every response retires one response-pc entry, kept or dropped.
            if (imem_rsp_valid) begin
                rpc_rd_reg <= rpc_rd_reg + PW'(1);
            end
            if (redirect_valid) begin
                fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
                drop_cnt_reg <= outstanding_next;
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                InstrD       <= NOP_INSTR;
                ValidD       <= 1'b0;
            end else begin
                if (imem_rsp_valid && (drop_cnt_reg != '0)) begin
                    drop_cnt_reg <= drop_cnt_reg - CW'(1);
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if (!stall_d) begin
                    if (count_reg != '0) begin
                        InstrD   <= q_instr[rd_ptr_reg];
                        PCD      <= q_pc[rd_ptr_reg];
                        PCPlus4D <= q_pc[rd_ptr_reg] + 32'd4;
                        ValidD   <= 1'b1;
                    end else begin
                        InstrD <= NOP_INSTR;
                        ValidD <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order, fixed-latency
// instruction memory model returning addr|0x13.
module tb_fetch_prefetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int edge_n = 0;
    int accept_cnt = 0;
    logic [31:0] last_acc_addr = 32'h0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    fetch_prefetch_queue dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // Memory model: decides at the negedge what the next posedge will see.
    always @(negedge clk) begin
        if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
        end else begin
            if (imem_rsp_valid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
                imem_rsp_valid = 1'b0;
            end
            if (imem_req_valid && imem_req_ready) begin
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(edge_n + 1 + lat);
                accept_cnt++;
                last_acc_addr = imem_req_addr;
                $display("req addr=%h", imem_req_addr);
            end
            if (pend_addr.size() > 0 && pend_due[0] == edge_n + 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_addr[0] | 32'h13;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy, input int l);
        rst = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = rdy; lat = l;
        tick(); tick();
        rst = 1'b0;
        accept_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall_d = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b1; lat = 1;
        tick(); tick();
        total++;
        if (InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
            bad++;
            $display("FAIL reset_d instr=%h pcd=%h pc4=%h v=%b want 00000013/0/0/0", InstrD, PCD, PCPlus4D, ValidD);
        end
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL reset_reqv got=%b want 0", imem_req_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL reset_release v=%b addr=%h want 1/00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] pc;
        do_reset(1'b1, 1);
        tick(); tick();
        total++;
        if (ValidD !== 1'b0) begin
            bad++; $display("FAIL seq_latency v=%b want 0", ValidD);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            pc = 32'(i * 4);
            total++;
            if (ValidD !== 1'b1 || PCD !== pc || PCPlus4D !== pc + 32'd4 || InstrD !== (pc | 32'h13)) begin
                bad++;
                $display("FAIL seq_d%0d v=%b pcd=%h pc4=%h instr=%h want 1/%h/%h/%h", i, ValidD, PCD, PCPlus4D, InstrD, pc, pc + 32'd4, pc | 32'h13);
            end
        end
        stall_d = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ValidD !== 1'b1 || PCD !== 32'h8 || InstrD !== 32'h1B) begin
                bad++; $display("FAIL seq_hold%0d v=%b pcd=%h instr=%h want 1/8/1b", i, ValidD, PCD, InstrD);
            end
        end
        stall_d = 1'b0;
        tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'hC || InstrD !== 32'h1F || PCPlus4D !== 32'h10) begin
            bad++; $display("FAIL seq_resume v=%b pcd=%h instr=%h pc4=%h want 1/c/1f/10", ValidD, PCD, InstrD, PCPlus4D);
        end
    endtask

    task automatic test_stall_full();
        logic [31:0] pc;
        do_reset(1'b1, 1);
        stall_d = 1'b1;
        repeat (10) tick();
        total++;
        if (accept_cnt != 4 || last_acc_addr !== 32'hC) begin
            bad++; $display("FAIL full_accepts cnt=%0d last=%h want 4/c", accept_cnt, last_acc_addr);
        end
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL full_reqv got=%b want 0", imem_req_valid);
        end
        total++;
        if (ValidD !== 1'b0 || InstrD !== 32'h13) begin
            bad++; $display("FAIL full_frozen v=%b instr=%h want 0/13", ValidD, InstrD);
        end
        stall_d = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pc = 32'(i * 4);
            total++;
            if (ValidD !== 1'b1 || PCD !== pc || InstrD !== (pc | 32'h13)) begin
                bad++; $display("FAIL full_drain%0d v=%b pcd=%h instr=%h want 1/%h/%h", i, ValidD, PCD, InstrD, pc, pc | 32'h13);
            end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset(1'b1, 3);
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        total++;
        if (imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL redir_noreq got=%b want 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            bad++; $display("FAIL redir_addr v=%b addr=%h want 1/100", imem_req_valid, imem_req_addr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ValidD !== 1'b0) begin
                bad++; $display("FAIL redir_stale%0d v=%b pcd=%h want bubble", i, ValidD, PCD);
            end
        end
        tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== 32'h113 || PCPlus4D !== 32'h104) begin
            bad++; $display("FAIL redir_first v=%b pcd=%h instr=%h pc4=%h want 1/100/113/104", ValidD, PCD, InstrD, PCPlus4D);
        end
    endtask

    task automatic test_redirect_rsp_stall();
        do_reset(1'b1, 1);
        tick(); tick(); tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h0) begin
            bad++; $display("FAIL rrs_pre v=%b pcd=%h want 1/0", ValidD, PCD);
        end
        stall_d = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
        tick();
        stall_d = 1'b0; redirect_valid = 1'b0;
        #1;
        total++;
        if (ValidD !== 1'b0 || InstrD !== 32'h13) begin
            bad++; $display("FAIL rrs_bubble v=%b instr=%h want 0/13", ValidD, InstrD);
        end
        total++;
        if (imem_req_addr !== 32'h100) begin
            bad++; $display("FAIL rrs_addr got=%h want 100", imem_req_addr);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (ValidD !== 1'b0) begin
                bad++; $display("FAIL rrs_drop%0d v=%b pcd=%h want bubble", i, ValidD, PCD);
            end
        end
        tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== 32'h113) begin
            bad++; $display("FAIL rrs_first v=%b pcd=%h instr=%h want 1/100/113", ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_ready_low();
        do_reset(1'b0, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || ValidD !== 1'b0) begin
                bad++; $display("FAIL rdy_hold%0d v=%b addr=%h d=%b want 1/0/0", i, imem_req_valid, imem_req_addr, ValidD);
            end
        end
        imem_req_ready = 1'b1;
        tick();
        total++;
        if (imem_req_addr !== 32'h4) begin
            bad++; $display("FAIL rdy_advance got=%h want 4", imem_req_addr);
        end
        tick(); tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'h13) begin
            bad++; $display("FAIL rdy_first v=%b pcd=%h instr=%h want 1/0/13", ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_wrap();
        do_reset(1'b1, 1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_start got=%h want fffffffc", imem_req_addr);
        end
        tick();
        total++;
        if (imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_next got=%h want 0", imem_req_addr);
        end
        tick(); tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || InstrD !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_d v=%b pcd=%h pc4=%h instr=%h want 1/fffffffc/0/ffffffff", ValidD, PCD, PCPlus4D, InstrD);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b1, 1);
        repeat (5) tick();
        total++;
        if (PCD !== 32'h8 || ValidD !== 1'b1) begin
            bad++; $display("FAIL mid_pre pcd=%h v=%b want 8/1", PCD, ValidD);
        end
        rst = 1'b1;
        tick();
        total++;
        if (InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0 || imem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset instr=%h pcd=%h pc4=%h v=%b rv=%b want 13/0/0/0/0", InstrD, PCD, PCPlus4D, ValidD, imem_req_valid);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL mid_release v=%b addr=%h want 1/0", imem_req_valid, imem_req_addr);
        end
        repeat (3) tick();
        total++;
        if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== 32'h13) begin
            bad++; $display("FAIL mid_first v=%b pcd=%h instr=%h want 1/0/13", ValidD, PCD, InstrD);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_full();
        test_redirect_drop();
        test_redirect_rsp_stall();
        test_ready_low();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
